arbiter: RTL and testbench

ARBITER -- requirements
Module: arbiter

---
 rtl/arbiter.sv | 128 ++++++++++++
 tb/tb_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/arbiter.sv
// Two-master Wishbone arbiter: instruction and data caches share one L2 bus.
// One grant at a time; ties alternate priority; a one-cycle RELEASE separates grants.
module arbiter (
    input  logic         clk,
    input  logic         rst,
    // instruction-cache slave port
    input  logic         icache_cyc_i,
    input  logic         icache_stb_i,
    input  logic         icache_we_i,
    input  logic [26:0]  icache_adr_i,
    input  logic [31:0]  icache_sel_i,
    input  logic [255:0] icache_dat_i,
    output logic         icache_ack_o,
    output logic         icache_rty_o,
    output logic [255:0] icache_dat_o,
    // data-cache slave port
    input  logic         dcache_cyc_i,
    input  logic         dcache_stb_i,
    input  logic         dcache_we_i,
    input  logic [26:0]  dcache_adr_i,
    input  logic [31:0]  dcache_sel_i,
    input  logic [255:0] dcache_dat_i,
    output logic         dcache_ack_o,
    output logic         dcache_rty_o,
    output logic [255:0] dcache_dat_o,
    // shared L2 master port
    output logic         l2_cyc_o,
    output logic         l2_stb_o,
    output logic         l2_we_o,
    output logic [26:0]  l2_adr_o,
    output logic [31:0]  l2_sel_o,
    output logic [255:0] l2_dat_o,
    input  logic         l2_ack_i,
    input  logic         l2_rty_i,
    input  logic [255:0] l2_dat_i
);

    localparam int unsigned AW = 27;
    localparam int unsigned SW = 32;
    localparam int unsigned DW = 256;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT_I = 2'd1,
        ST_GRANT_D = 2'd2,
        ST_RELEASE = 2'd3
    } state_e;

    state_e state_q, state_d;
    logic   last_d_q, last_d_d;   // 1: last grant went to dcache

    logic i_pend, d_pend;
    assign i_pend = icache_cyc_i & icache_stb_i;
    assign d_pend = dcache_cyc_i & dcache_stb_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            last_d_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_d_d     = last_d_q;
        l2_cyc_o     = 1'b0;
        l2_stb_o     = 1'b0;
        l2_we_o      = 1'b0;
        l2_adr_o     = AW'(0);
        l2_sel_o     = SW'(0);
        l2_dat_o     = DW'(0);
        icache_ack_o = 1'b0;
        icache_rty_o = 1'b0;
        dcache_ack_o = 1'b0;
        dcache_rty_o = 1'b0;
        icache_dat_o = l2_dat_i;
        dcache_dat_o = l2_dat_i;

        case (state_q)
            ST_IDLE: begin
                // dcache wins a tie unless it had the previous grant
                if (d_pend && (!i_pend || !last_d_q)) begin
                    state_d = ST_GRANT_D;
                end else if (i_pend) begin
                    state_d = ST_GRANT_I;
                end
            end
            ST_GRANT_I: begin
                l2_cyc_o     = icache_cyc_i;
                l2_stb_o     = icache_stb_i;
                l2_we_o      = icache_we_i;
                l2_adr_o     = icache_adr_i;
                l2_sel_o     = icache_sel_i;
                l2_dat_o     = icache_dat_i;
                icache_ack_o = l2_ack_i;
                icache_rty_o = l2_rty_i;
                if (!icache_cyc_i || l2_ack_i || l2_rty_i) begin
                    state_d  = ST_RELEASE;
                    last_d_d = 1'b0;
                end
            end
            ST_GRANT_D: begin
                l2_cyc_o     = dcache_cyc_i;
                l2_stb_o     = dcache_stb_i;
                l2_we_o      = dcache_we_i;
                l2_adr_o     = dcache_adr_i;
                l2_sel_o     = dcache_sel_i;
                l2_dat_o     = dcache_dat_i;
                dcache_ack_o = l2_ack_i;
                dcache_rty_o = l2_rty_i;
                if (!dcache_cyc_i || l2_ack_i || l2_rty_i) begin
                    state_d  = ST_RELEASE;
                    last_d_d = 1'b1;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_arbiter.sv
// Directed self-checking bench for the two-master L2 arbiter.
module tb_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         ic_cyc, ic_stb, ic_we;
    logic [26:0]  ic_adr;
    logic [31:0]  ic_sel;
    logic [255:0] ic_datm;
    logic         ic_ack, ic_rty;
    logic [255:0] ic_dats;
    logic         dc_cyc, dc_stb, dc_we;
    logic [26:0]  dc_adr;
    logic [31:0]  dc_sel;
    logic [255:0] dc_datm;
    logic         dc_ack, dc_rty;
    logic [255:0] dc_dats;
    logic         l2_cyc, l2_stb, l2_we;
    logic [26:0]  l2_adr;
    logic [31:0]  l2_sel;
    logic [255:0] l2_datm;
    logic         l2_ack, l2_rty;
    logic [255:0] l2_dats;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [255:0] PAT_A5 = {32{8'hA5}};
    localparam logic [255:0] PAT_WR = {8{32'h12345678}};

    arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .icache_cyc_i (ic_cyc),
        .icache_stb_i (ic_stb),
        .icache_we_i  (ic_we),
        .icache_adr_i (ic_adr),
        .icache_sel_i (ic_sel),
        .icache_dat_i (ic_datm),
        .icache_ack_o (ic_ack),
        .icache_rty_o (ic_rty),
        .icache_dat_o (ic_dats),
        .dcache_cyc_i (dc_cyc),
        .dcache_stb_i (dc_stb),
        .dcache_we_i  (dc_we),
        .dcache_adr_i (dc_adr),
        .dcache_sel_i (dc_sel),
        .dcache_dat_i (dc_datm),
        .dcache_ack_o (dc_ack),
        .dcache_rty_o (dc_rty),
        .dcache_dat_o (dc_dats),
        .l2_cyc_o     (l2_cyc),
        .l2_stb_o     (l2_stb),
        .l2_we_o      (l2_we),
        .l2_adr_o     (l2_adr),
        .l2_sel_o     (l2_sel),
        .l2_dat_o     (l2_datm),
        .l2_ack_i     (l2_ack),
        .l2_rty_i     (l2_rty),
        .l2_dat_i     (l2_dats)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a downstream cycle to appear, then check its address.
    task automatic wait_grant(input string tag, input logic [26:0] exp_adr);
        int n = 0;
        @(negedge clk);
        while (!l2_cyc && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_cyc"}, 256'(l2_cyc), 256'(1));
        chk({tag, "_adr"}, 256'(l2_adr), 256'(exp_adr));
    endtask

    // Memory terminates the granted cycle with ACK (or RTY); ends at the RELEASE negedge.
    task automatic complete(input string tag, input bit is_d, input bit use_rty);
        l2_dats = PAT_A5 ^ 256'(n_checks);
        if (use_rty) l2_rty = 1'b1;
        else         l2_ack = 1'b1;
        #1;
        chk({tag, "_ack"},  256'(is_d ? dc_ack : ic_ack), 256'(!use_rty));
        chk({tag, "_rty"},  256'(is_d ? dc_rty : ic_rty), 256'(use_rty));
        chk({tag, "_oack"}, 256'(is_d ? ic_ack : dc_ack), 256'(0));
        chk({tag, "_orty"}, 256'(is_d ? ic_rty : dc_rty), 256'(0));
        chk({tag, "_dat"},  is_d ? dc_dats : ic_dats, l2_dats);
        @(negedge clk);
        l2_ack = 1'b0;
        l2_rty = 1'b0;
        #1;
        chk({tag, "_rel"}, 256'(l2_cyc), 256'(0));
    endtask

    initial begin
        rst = 1'b1;
        ic_cyc = 0; ic_stb = 0; ic_we = 0; ic_adr = '0; ic_sel = '0; ic_datm = '0;
        dc_cyc = 0; dc_stb = 0; dc_we = 0; dc_adr = '0; dc_sel = '0; dc_datm = '0;
        l2_ack = 0; l2_rty = 0; l2_dats = '0;

        // reset state, with a request held during reset
        repeat (2) @(negedge clk);
        ic_cyc = 1; ic_stb = 1; ic_adr = 27'h0000100; ic_sel = '1;
        @(negedge clk);
        chk("rst_cyc", 256'(l2_cyc), 256'(0));
        chk("rst_stb", 256'(l2_stb), 256'(0));
        chk("rst_adr", 256'(l2_adr), 256'(0));
        chk("rst_sel", 256'(l2_sel), 256'(0));
        chk("rst_ack", 256'({ic_ack, dc_ack, ic_rty, dc_rty}), 256'(0));

        // icache-only read: one-cycle arbitration latency
        rst = 1'b0;
        #1;
        chk("t1_lat0", 256'(l2_cyc), 256'(0));
        @(negedge clk);
        chk("t1_cyc", 256'({l2_cyc, l2_stb}), 256'(2'b11));
        chk("t1_adr", 256'(l2_adr), 256'(27'h0000100));
        chk("t1_we",  256'(l2_we), 256'(0));
        l2_dats = PAT_A5;
        l2_ack  = 1'b1;
        #1;
        chk("t1_ack",  256'(ic_ack), 256'(1));
        chk("t1_dat",  ic_dats, PAT_A5);
        chk("t1_dack", 256'(dc_ack), 256'(0));
        @(negedge clk);
        l2_ack = 1'b0;
        ic_cyc = 0; ic_stb = 0;
        #1;
        chk("t1_rel", 256'(l2_cyc), 256'(0));

        // simultaneous after reset: dcache first, then icache
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        ic_cyc = 1; ic_stb = 1; ic_adr = 27'h10;
        dc_cyc = 1; dc_stb = 1; dc_adr = 27'h20; dc_sel = '1;
        wait_grant("t2_d", 27'h20);
        chk("t2_iack", 256'(ic_ack), 256'(0));
        complete("t2_d", 1'b1, 1'b0);
        dc_cyc = 0; dc_stb = 0;
        #1;
        chk("t2_gap", 256'(l2_cyc), 256'(0));
        wait_grant("t2_i", 27'h10);
        complete("t2_i", 1'b0, 1'b0);
        ic_cyc = 0; ic_stb = 0;

        // dcache write held across an icache request
        dc_cyc = 1; dc_stb = 1; dc_we = 1; dc_adr = 27'h40; dc_sel = 32'hFFFFFFFF; dc_datm = PAT_WR;
        wait_grant("t3_d", 27'h40);
        chk("t3_we",  256'(l2_we), 256'(1));
        chk("t3_sel", 256'(l2_sel), 256'(32'hFFFFFFFF));
        chk("t3_dat", l2_datm, PAT_WR);
        ic_cyc = 1; ic_stb = 1; ic_we = 0; ic_adr = 27'h50; ic_datm = PAT_A5;
        repeat (2) @(negedge clk);
        chk("t3_hold_we",  256'(l2_we), 256'(1));
        chk("t3_hold_dat", l2_datm, PAT_WR);
        chk("t3_hold_adr", 256'(l2_adr), 256'(27'h40));
        chk("t3_hold_iack", 256'(ic_ack), 256'(0));
        complete("t3_d", 1'b1, 1'b0);
        dc_cyc = 0; dc_stb = 0; dc_we = 0;
        wait_grant("t3_i", 27'h50);
        complete("t3_i", 1'b0, 1'b0);

        // continuous simultaneous requests: D, I, D, I
        dc_cyc = 1; dc_stb = 1; dc_adr = 27'h60;
        for (int k = 0; k < 4; k++) begin
            wait_grant((k % 2 == 0) ? "t4_d" : "t4_i", (k % 2 == 0) ? 27'h60 : 27'h50);
            complete((k % 2 == 0) ? "t4_d" : "t4_i", (k % 2 == 0), 1'b0);
        end
        dc_cyc = 0; dc_stb = 0;

        // reset during an icache grant
        wait_grant("t5_i", 27'h50);
        rst = 1'b1; l2_ack = 1'b1;
        #1;
        chk("t5_cyc", 256'(l2_cyc), 256'(0));
        chk("t5_ack", 256'(ic_ack), 256'(0));
        @(negedge clk);
        rst = 1'b0; l2_ack = 1'b0;
        #1;
        chk("t5_idle", 256'(l2_cyc), 256'(0));
        @(negedge clk);
        chk("t5_regrant", 256'(l2_adr), 256'(27'h50));
        complete("t5_i", 1'b0, 1'b0);
        ic_cyc = 0; ic_stb = 0;

        // dcache abandons; pending icache then granted and retried
        dc_cyc = 1; dc_stb = 1; dc_adr = 27'h70;
        wait_grant("t6_d", 27'h70);
        ic_cyc = 1; ic_stb = 1; ic_adr = 27'h80;
        @(negedge clk);
        dc_cyc = 0; dc_stb = 0;
        #1;
        chk("t6_drop", 256'(l2_cyc), 256'(0));
        @(negedge clk);
        chk("t6_rel", 256'(l2_cyc), 256'(0));
        chk("t6_rel_iack", 256'(ic_ack), 256'(0));
        wait_grant("t6_i", 27'h80);
        complete("t6_i", 1'b0, 1'b1);
        ic_cyc = 0; ic_stb = 0;

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
